// File: rtl/audio_pkg.sv
// Shared types and helpers for the PWM audio frame scheduler.
// FSM states, divider/width helpers and the midscale mute word.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  function automatic int calc_divider(input int sys_hz,
                                      input int samp_hz);
    return sys_hz / samp_hz;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] mute_word(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/audio_frame_scheduler_sample_fifo.sv
// sample_fifo: synchronous FIFO, power-of-two depth, show-ahead read.
// Ports: clock_i, reset_n_i, push, wdata, pop, rdata, full, empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_frame_scheduler.sv
// Buffers samples and frames them onto the PWM serializer each sample tick.
// Ports: clock_i/reset_n_i, enable_i, sample_* handshake, ser_* serializer
// side, busy/underrun/overrun/error status. Option macro:
// AUDIO_SCHED_MUTE_ON_UNDERRUN_EN sends midscale on underrun and at reset.
module audio_frame_scheduler
  import audio_pkg::*;
#(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [WORD_LENGTH-1:0] sample_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  output logic [WORD_LENGTH-1:0] ser_data_o,
  output logic                   ser_enable_o,
  input  logic                   ser_done_i,
  output logic                   busy_o,
  output logic                   underrun_o,
  output logic                   overrun_o,
  output logic                   error_o
);

  localparam int DIVIDER = calc_divider(SYSTEM_FREQUENCY,
                                        SAMPLING_FREQUENCY);
  localparam int CW = cnt_width(DIVIDER);
  localparam int BW = cnt_width(WORD_LENGTH);

`ifdef AUDIO_SCHED_MUTE_ON_UNDERRUN_EN
  localparam logic [31:0] MUTE32 = mute_word(WORD_LENGTH);
  localparam logic [WORD_LENGTH-1:0] DATA_RST = MUTE32[WORD_LENGTH-1:0];
`else
  localparam logic [WORD_LENGTH-1:0] DATA_RST = '0;
`endif

  if (DIVIDER < WORD_LENGTH + 3) begin : g_bad_divider
    $error("audio_frame_scheduler: DIVIDER < WORD_LENGTH + 3");
  end

  sched_state_t     state;
  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic [BW-1:0]    bit_cnt;
  logic             wd_cnt;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [WORD_LENGTH-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign tick           = enable_i && (tick_cnt == CW'(DIVIDER - 1));
  assign sample_ready_o = !fifo_full;
  assign fifo_push      = sample_valid_i && !fifo_full;
  assign fifo_pop       = (state == ST_IDLE) && tick && !fifo_empty;
  assign busy_o         = (state != ST_IDLE);

  sample_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push      (fifo_push),
    .wdata     (sample_i),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tick_cnt <= '0;
    end else if (!enable_i || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      wd_cnt       <= 1'b0;
      ser_data_o   <= DATA_RST;
      ser_enable_o <= 1'b0;
      underrun_o   <= 1'b0;
      overrun_o    <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      overrun_o  <= tick && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (tick) begin
            if (!fifo_empty) begin
              ser_data_o <= fifo_rdata;
            end else begin
              underrun_o <= 1'b1;
`ifdef AUDIO_SCHED_MUTE_ON_UNDERRUN_EN
              ser_data_o <= DATA_RST;
`endif
            end
            ser_enable_o <= 1'b1;
            bit_cnt      <= BW'(WORD_LENGTH - 1);
            state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            ser_enable_o <= 1'b0;
            wd_cnt       <= 1'b0;
            state        <= ST_WAIT_DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          // Done may arrive on the entry cycle or the one after.
          if (ser_done_i) begin
            state <= ST_IDLE;
          end else if (wd_cnt) begin
            error_o <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wd_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
